srp16_run_ctrl: RTL

// Synthesizable run/step controller for the SRP16 core: sequences core reset, gates the core clock

---
 rtl/srp16_run_ctrl_pkg.sv | 25 ++
 rtl/srp16_bp_match.sv | 26 ++
 rtl/srp16_run_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/srp16_run_ctrl_pkg.sv
// srp16_run_ctrl_pkg
// Shared encodings for the SRP16 run/step controller: host command opcodes,
// run-termination causes and the 2-bit controller state codes.
// No ports; imported by srp16_run_ctrl and its bench.
package srp16_run_ctrl_pkg;

  // host command opcodes (cmd_op)
  localparam logic [1:0] OP_RUN        = 2'b00;
  localparam logic [1:0] OP_RUN_N      = 2'b01;
  localparam logic [1:0] OP_STEP       = 2'b10;
  localparam logic [1:0] OP_RESET_CORE = 2'b11;

  // run termination causes (done_cause)
  localparam logic [1:0] CAUSE_BUDGET  = 2'b00;
  localparam logic [1:0] CAUSE_HALT    = 2'b01;
  localparam logic [1:0] CAUSE_BP      = 2'b10;
  localparam logic [1:0] CAUSE_STOP    = 2'b11;

  // controller states
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CORE_RST   = 2'd1;
  localparam logic [1:0] ST_RUN        = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

endpackage

// File: rtl/srp16_bp_match.sv
// srp16_bp_match
// Combinational PC breakpoint comparator array. Flags a hit when any enabled
// breakpoint address equals the current core PC.
// Ports:
//   pc      in  ADDR_W         core program counter
//   bp_en   in  NUM_BP         per-breakpoint enable
//   bp_addr in  NUM_BP*ADDR_W  breakpoint i at [i*ADDR_W +: ADDR_W]
//   hit     out 1              any enabled breakpoint matches pc
module srp16_bp_match #(
  parameter int NUM_BP = 2,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]        pc,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  output logic                     hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (pc == bp_addr[i*ADDR_W +: ADDR_W])) hit = 1'b1;
    end
  end

endmodule

// File: rtl/srp16_run_ctrl.sv
// srp16_run_ctrl
// Run/step controller for the SRP16 core. Sequences core reset, gates the
// core clock enable and runs free or for a cycle budget, stopping on core
// halt, PC breakpoint or external stop.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   cmd_valid/ready/op/arg host command handshake (accepted only in IDLE)
//   stop                   external stop request
//   bp_en, bp_addr         breakpoint enables and addresses (live)
//   core_pc, core_halt     core status
//   core_reset, core_ce    core control
//   running                high while running
//   done_valid, done_cause end-of-run pulse and held cause
//   cycle_count            enabled core cycles since last core reset, saturating
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// CORE_RST | core_reset held for RST_LEN cycles
// RUN      | core enabled unless a stop condition is seen this cycle
// DONE     | one-cycle done_valid pulse
module srp16_run_ctrl
  import srp16_run_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 32,
  parameter int RST_LEN = 2,
  parameter int NUM_BP  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_arg,
  input  logic                     stop,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0]        core_pc,
  input  logic                     core_halt,
  output logic                     core_reset,
  output logic                     core_ce,
  output logic                     running,
  output logic                     done_valid,
  output logic [1:0]               done_cause,
  output logic [CNT_W-1:0]         cycle_count
);

  localparam int RW = $clog2(RST_LEN + 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_LEN - 1);

  logic [1:0]       state;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] remaining;
  logic             bounded;
  logic             first_cyc;

  logic             bp_raw;
  logic             bp_hit;
  logic             budget_hit;
  logic             any_hit;
  logic [1:0]       hit_cause;

  srp16_bp_match #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W)
  ) u_bp_match (
    .pc      (core_pc),
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .hit     (bp_raw)
  );

  // Breakpoints are masked on the first run cycle so a run can resume from
  // the PC it last stopped on.
  always_comb begin
    bp_hit     = bp_raw & ~first_cyc;
    budget_hit = bounded & (remaining == '0);
    any_hit    = core_halt | bp_hit | stop | budget_hit;
    hit_cause  = CAUSE_BUDGET;
    if (core_halt)   hit_cause = CAUSE_HALT;
    else if (bp_hit) hit_cause = CAUSE_BP;
    else if (stop)   hit_cause = CAUSE_STOP;
  end

  assign cmd_ready  = (state == ST_IDLE);
  assign core_reset = (state == ST_CORE_RST);
  assign running    = (state == ST_RUN);
  assign done_valid = (state == ST_DONE);
  assign core_ce    = running & ~any_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CORE_RST;
      rst_cnt     <= RST_LOAD;
      remaining   <= '0;
      bounded     <= 1'b0;
      first_cyc   <= 1'b0;
      done_cause  <= CAUSE_BUDGET;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_RESET_CORE: begin
                state       <= ST_CORE_RST;
                rst_cnt     <= RST_LOAD;
                cycle_count <= '0;
              end
              OP_RUN: begin
                state     <= ST_RUN;
                bounded   <= 1'b0;
                first_cyc <= 1'b1;
              end
              OP_RUN_N: begin
                if (cmd_arg == '0) begin
                  // empty budget finishes without ever enabling the core
                  state      <= ST_DONE;
                  done_cause <= CAUSE_BUDGET;
                end else begin
                  state     <= ST_RUN;
                  bounded   <= 1'b1;
                  remaining <= cmd_arg;
                  first_cyc <= 1'b1;
                end
              end
              default: begin
                state     <= ST_RUN;
                bounded   <= 1'b1;
                remaining <= CNT_W'(1);
                first_cyc <= 1'b1;
              end
            endcase
          end
        end
        ST_CORE_RST: begin
          if (rst_cnt == '0) state <= ST_IDLE;
          else               rst_cnt <= rst_cnt - RW'(1);
        end
        ST_RUN: begin
          first_cyc <= 1'b0;
          if (any_hit) begin
            state      <= ST_DONE;
            done_cause <= hit_cause;
          end else begin
            if (bounded) remaining <= remaining - CNT_W'(1);
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
